// File: rtl/irb_pkg.sv
// -----------------------------------------------------------------------------
// irb_pkg
// Shared sizing and types for the PW-kernel tile RAM sequencer.
//   KPW_N_ELEM : tile RAM depth in entries
//   WG_W, Npar : weight width and parallelism; an entry is WG_W + $clog2(Npar+1) bits
//   KPW_DW     : RAM entry / stream data width
//   KPW_AW     : RAM address / element-count width
//   kpw_state_t: kpw_tile_ctrl FSM states
// -----------------------------------------------------------------------------
package irb_pkg;

    localparam int KPW_N_ELEM = 16;
    localparam int WG_W       = 8;
    localparam int Npar       = 4;
    localparam int KPW_DW     = WG_W + $clog2(Npar + 1);
    localparam int KPW_AW     = $clog2(KPW_N_ELEM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        READ  = 2'd3
    } kpw_state_t;

endpackage

// File: rtl/kpw_skid_buf.sv
// -----------------------------------------------------------------------------
// kpw_skid_buf
// Two-entry valid/ready FIFO that absorbs RAM read data while the consumer
// stalls. Flush is synchronous and empties the buffer.
//   clk        in   clock
//   flush      in   synchronous flush (empties buffer)
//   in_valid   in   push strobe (caller guarantees room)
//   in_data    in   DW-bit push data
//   out_valid  out  buffer non-empty
//   out_ready  in   consumer accepts head entry
//   out_data   out  head entry
//   count      out  current occupancy (0..2)
// -----------------------------------------------------------------------------
module kpw_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [0:1];
    logic          wptr;
    logic          rptr;
    logic          push;
    logic          pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rptr];
    assign push      = in_valid && (count != 2'd2);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (flush) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

endmodule

// File: rtl/kpw_tile_ctrl.sv
// -----------------------------------------------------------------------------
// kpw_tile_ctrl
// Loads a PW kernel tile from the weight stream into RAM_KPW, then replays it
// cfg_n_pass times to the PW datapath as a valid/ready stream.
// Optional feature macro: KPW_PERF_CNT_EN adds stall_cnt[31:0].
//   clk, reset       clock, synchronous active-high reset
//   cfg_n_elem       tile entries, sampled on accepted start_load
//   cfg_n_pass       replay count, sampled on accepted start_rd
//   start_load       pulse: begin tile load
//   start_rd         pulse: begin replay
//   ld_valid/ld_data/ld_ready   load stream
//   ram_addr/ram_data/ram_write RAM port (sole owner)
//   ram_res          RAM read data, 1-cycle latency
//   rd_valid/rd_data/rd_last/rd_ready replay stream
//   tile_ready       tile complete and replayable
//   busy             in LOAD or READ
//   done             1-cycle pulse after final entry of final pass accepted
//   stall_cnt        (KPW_PERF_CNT_EN) READ cycles with rd_valid & !rd_ready
// -----------------------------------------------------------------------------
module kpw_tile_ctrl
    import irb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [KPW_AW-1:0] cfg_n_elem,
    input  logic [7:0]        cfg_n_pass,
    input  logic              start_load,
    input  logic              start_rd,
    input  logic              ld_valid,
    input  logic [KPW_DW-1:0] ld_data,
    output logic              ld_ready,
    output logic [KPW_AW-1:0] ram_addr,
    output logic [KPW_DW-1:0] ram_data,
    output logic              ram_write,
    input  logic [KPW_DW-1:0] ram_res,
    output logic              rd_valid,
    output logic [KPW_DW-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              tile_ready,
`ifdef KPW_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              busy,
    output logic              done
);

    kpw_state_t        state;
    logic [KPW_AW-1:0] wr_cnt;
    logic [KPW_AW-1:0] rd_cnt;
    logic [KPW_AW-1:0] n_elem;
    logic [7:0]        pass_cnt;
    logic [7:0]        n_pass;

    // Read issued last cycle plus its pass-position tags.
    logic              inflight;
    logic              inflight_last;
    logic              inflight_final;

    logic              skid_valid;
    logic [KPW_DW+1:0] skid_data;
    logic [1:0]        skid_cnt;
    logic              skid_final;

    logic              load_ok;
    logic              rd_accept;
    logic              wr_fire;
    logic              pop;
    logic              room;
    logic              issue;
    logic              issue_last;
    logic              issue_final;
    logic [7:0]        eff_pass;
    logic [7:0]        eff_npass;

    assign load_ok   = start_load && (cfg_n_elem != '0) && (cfg_n_elem <= KPW_AW'(KPW_N_ELEM));
    assign rd_accept = (state == READY) && start_rd && (cfg_n_pass != 8'd0);
    assign wr_fire   = (state == LOAD) && ld_valid;
    assign pop       = skid_valid && rd_ready;

    // Room counts the read still in flight; an entry popped this cycle frees a slot.
    assign room      = ({1'b0, skid_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

    // The first address is issued in the accepting cycle so data appears two
    // cycles after start_rd; rd_cnt is always 0 outside READ.
    assign eff_pass    = (state == READ) ? pass_cnt : 8'd0;
    assign eff_npass   = (state == READ) ? n_pass : cfg_n_pass;
    assign issue       = rd_accept || ((state == READ) && (pass_cnt != n_pass) && room);
    assign issue_last  = (rd_cnt == n_elem - KPW_AW'(1));
    assign issue_final = issue_last && (eff_pass == eff_npass - 8'd1);

    assign ld_ready   = (state == LOAD);
    assign ram_write  = wr_fire;
    assign ram_addr   = (state == LOAD) ? wr_cnt : rd_cnt;
    assign ram_data   = (state == LOAD) ? ld_data : '0;
    assign busy       = (state == LOAD) || (state == READ);

    assign rd_valid   = skid_valid;
    assign rd_data    = skid_valid ? skid_data[KPW_DW-1:0] : '0;
    assign rd_last    = skid_valid && skid_data[KPW_DW];
    assign skid_final = skid_data[KPW_DW+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            n_elem         <= '0;
            pass_cnt       <= '0;
            n_pass         <= '0;
            inflight       <= 1'b0;
            inflight_last  <= 1'b0;
            inflight_final <= 1'b0;
            tile_ready     <= 1'b0;
            done           <= 1'b0;
        end else begin
            inflight       <= issue;
            inflight_last  <= issue_last;
            inflight_final <= issue_final;
            done           <= pop && skid_final;

            case (state)
                IDLE: begin
                    if (load_ok) begin
                        state      <= LOAD;
                        n_elem     <= cfg_n_elem;
                        wr_cnt     <= '0;
                        tile_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + KPW_AW'(1);
                        if (wr_cnt == n_elem - KPW_AW'(1)) begin
                            state      <= READY;
                            tile_ready <= 1'b1;
                        end
                    end
                end
                READY: begin
                    // Any start_rd pulse masks a simultaneous start_load.
                    if (rd_accept) begin
                        state  <= READ;
                        n_pass <= cfg_n_pass;
                    end else if (load_ok && !start_rd) begin
                        state      <= LOAD;
                        n_elem     <= cfg_n_elem;
                        wr_cnt     <= '0;
                        tile_ready <= 1'b0;
                    end
                end
                READ: begin
                    if (pop && skid_final) state <= READY;
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                if (issue_last) begin
                    rd_cnt   <= '0;
                    pass_cnt <= eff_pass + 8'd1;
                end else begin
                    rd_cnt   <= rd_cnt + KPW_AW'(1);
                    pass_cnt <= eff_pass;
                end
            end
        end
    end

    kpw_skid_buf #(
        .DW (KPW_DW + 2)
    ) u_skid (
        .clk       (clk),
        .flush     (reset),
        .in_valid  (inflight),
        .in_data   ({inflight_final, inflight_last, ram_res}),
        .out_valid (skid_valid),
        .out_ready (rd_ready),
        .out_data  (skid_data),
        .count     (skid_cnt)
    );

`ifdef KPW_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || rd_accept) begin
            stall_cnt <= '0;
        end else if ((state == READ) && skid_valid && !rd_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kpw_tile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kpw_tile_ctrl
// Directed bench for kpw_tile_ctrl with a behavioural 1-cycle-latency RAM.
// -----------------------------------------------------------------------------
module tb_kpw_tile_ctrl;
    import irb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [KPW_AW-1:0] cfg_n_elem;
    logic [7:0]        cfg_n_pass;
    logic              start_load;
    logic              start_rd;
    logic              ld_valid;
    logic [KPW_DW-1:0] ld_data;
    logic              ld_ready;
    logic [KPW_AW-1:0] ram_addr;
    logic [KPW_DW-1:0] ram_data;
    logic              ram_write;
    logic [KPW_DW-1:0] ram_res;
    logic              rd_valid;
    logic [KPW_DW-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;
    logic              tile_ready;
    logic              busy;
    logic              done;
`ifdef KPW_PERF_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [KPW_DW-1:0] ram_mem [0:KPW_N_ELEM-1];
    logic [KPW_DW-1:0] got_d [$];
    logic              got_l [$];
    int                done_cnt = 0;

    logic [KPW_DW-1:0] dat4  [0:3];
    logic [KPW_DW-1:0] dat16 [0:KPW_N_ELEM-1];

    always #5 clk = ~clk;

    kpw_tile_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_n_elem (cfg_n_elem),
        .cfg_n_pass (cfg_n_pass),
        .start_load (start_load),
        .start_rd   (start_rd),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_write  (ram_write),
        .ram_res    (ram_res),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_ready   (rd_ready),
        .tile_ready (tile_ready),
`ifdef KPW_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .busy       (busy),
        .done       (done)
    );

    // Behavioural RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_write && (ram_addr < KPW_AW'(KPW_N_ELEM))) ram_mem[ram_addr[KPW_AW-2:0]] <= ram_data;
        ram_res <= (ram_addr < KPW_AW'(KPW_N_ELEM)) ? ram_mem[ram_addr[KPW_AW-2:0]] : '0;
    end

    // Handshake and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            got_d.push_back(rd_data);
            got_l.push_back(rd_last);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int base;
        int base_done;
        int cyc;
        int idx;
        logic hs;

        dat4[0] = 11'h0A1; dat4[1] = 11'h0B2; dat4[2] = 11'h0C3; dat4[3] = 11'h7D4;
        for (int i = 0; i < KPW_N_ELEM; i++) dat16[i] = KPW_DW'(i * 37 + 5);

        reset = 1'b1; cfg_n_elem = '0; cfg_n_pass = '0; start_load = 1'b0; start_rd = 1'b0;
        ld_valid = 1'b0; ld_data = '0; rd_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        // Reset state.
        check("rst_outputs", {ld_ready, ram_write, rd_valid, rd_last, tile_ready, busy, done}, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);

        // Test 1: load four entries with ld_valid held high.
        cfg_n_elem = 4; start_load = 1'b1; ld_valid = 1'b1; ld_data = dat4[0];
        step();
        start_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_data = dat4[i];
            #1;
            check("ld_ready", ld_ready, 32'h1);
            check("ld_write", ram_write, 32'h1);
            check("ld_addr", ram_addr, i);
            check("ld_data", ram_data, dat4[i]);
            check("ld_tile_ready_low", tile_ready, 32'h0);
            step();
        end
        check("ld_tile_ready", tile_ready, 32'h1);
        check("ld_ready_after", ld_ready, 32'h0);
        check("ld_write_after", ram_write, 32'h0);
        check("ld_busy_after", busy, 32'h0);
        ld_valid = 1'b0;

        // Test 2: two passes at full throughput.
        cfg_n_pass = 2; start_rd = 1'b1; rd_ready = 1'b1;
        base_done = done_cnt;
        step();
        start_rd = 1'b0;
        check("t2_c1_valid", rd_valid, 32'h0);
        check("t2_c1_busy", busy, 32'h1);
        for (int c = 2; c <= 9; c++) begin
            step();
            check("t2_valid", rd_valid, 32'h1);
            check("t2_data", rd_data, dat4[(c - 2) % 4]);
            check("t2_last", rd_last, ((c - 2) % 4 == 3) ? 32'h1 : 32'h0);
            check("t2_done_low", done, 32'h0);
        end
        step();
        check("t2_done", done, 32'h1);
        check("t2_valid_end", rd_valid, 32'h0);
        check("t2_busy_end", busy, 32'h0);
        check("t2_tile_ready", tile_ready, 32'h1);
        step();
        check("t2_done_pulse", done, 32'h0);
        check("t2_done_count", done_cnt - base_done, 32'h1);

        // Test 3: stall, then random rd_ready; sequence must be intact.
        base = got_d.size();
        base_done = done_cnt;
        cfg_n_pass = 2; start_rd = 1'b1; rd_ready = 1'b0;
        step();
        start_rd = 1'b0;
        check("t3_c1_addr", ram_addr, 32'h1);
        for (int c = 2; c <= 5; c++) begin
            step();
            check("t3_stall_addr", ram_addr, 32'h2);
            check("t3_stall_valid", rd_valid, 32'h1);
            check("t3_stall_data", rd_data, dat4[0]);
        end
        cyc = 0;
        while ((done_cnt == base_done) && (cyc < 200)) begin
            rd_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        rd_ready = 1'b1;
        check("t3_timeout", (cyc < 200) ? 32'h1 : 32'h0, 32'h1);
        check("t3_count", got_d.size() - base, 32'd8);
        for (int k = 0; k < 8; k++) begin
            idx = base + k;
            if (idx < got_d.size()) begin
                check("t3_data", got_d[idx], dat4[k % 4]);
                check("t3_last", got_l[idx], (k % 4 == 3) ? 32'h1 : 32'h0);
            end
        end
        step();

        // Test 4: invalid starts ignored in READY.
        cfg_n_pass = 0; start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        check("t4_npass0_busy", busy, 32'h0);
        check("t4_npass0_tile", tile_ready, 32'h1);
        check("t4_npass0_valid", rd_valid, 32'h0);
        cfg_n_elem = 0; start_load = 1'b1;
        step();
        check("t4_nelem0_ldready", ld_ready, 32'h0);
        check("t4_nelem0_tile", tile_ready, 32'h1);
        cfg_n_elem = KPW_AW'(KPW_N_ELEM + 1);
        step();
        start_load = 1'b0;
        check("t4_nelem_big_ldready", ld_ready, 32'h0);
        check("t4_nelem_big_busy", busy, 32'h0);
        check("t4_nelem_big_tile", tile_ready, 32'h1);

        // Test 5: start_load and start_rd together; then reset mid-READ.
        cfg_n_elem = 2; cfg_n_pass = 1; start_load = 1'b1; start_rd = 1'b1; rd_ready = 1'b0;
        step();
        start_load = 1'b0; start_rd = 1'b0;
        check("t5_busy", busy, 32'h1);
        check("t5_ldready", ld_ready, 32'h0);
        check("t5_tile", tile_ready, 32'h1);
        step();
        check("t5_data", rd_data, dat4[0]);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5_rst_outputs", {ld_ready, ram_write, rd_valid, rd_last, tile_ready, busy, done}, 32'h0);
        check("t5_rst_addr", ram_addr, 32'h0);
        cfg_n_pass = 1; start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        check("t5_idle_rd_ignored", busy, 32'h0);

        // Test 6: full-depth tile with bubbles on load, three passes, 10-cycle stall.
        cfg_n_elem = KPW_AW'(KPW_N_ELEM); start_load = 1'b1; ld_valid = 1'b0;
        step();
        start_load = 1'b0;
        idx = 0; cyc = 0;
        while (!tile_ready && (cyc < 100)) begin
            ld_valid = (cyc % 2 == 0) && (idx < KPW_N_ELEM);
            ld_data  = dat16[idx % KPW_N_ELEM];
            #1;
            hs = ld_valid && ld_ready;
            step();
            if (hs) idx++;
            cyc++;
        end
        ld_valid = 1'b0;
        check("t6_load_timeout", tile_ready, 32'h1);
        check("t6_load_count", idx, KPW_N_ELEM);

        base = got_d.size();
        base_done = done_cnt;
        cfg_n_pass = 3; start_rd = 1'b1; rd_ready = 1'b1;
        step();
        start_rd = 1'b0;
        cyc = 0;
        while ((got_d.size() - base < 20) && (cyc < 100)) begin
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        repeat (10) step();
        rd_ready = 1'b1;
        cyc = 0;
        while ((done_cnt == base_done) && (cyc < 200)) begin
            step();
            cyc++;
        end
        check("t6_timeout", (cyc < 200) ? 32'h1 : 32'h0, 32'h1);
        check("t6_count", got_d.size() - base, 3 * KPW_N_ELEM);
        for (int k = 0; k < 3 * KPW_N_ELEM; k++) begin
            idx = base + k;
            if (idx < got_d.size()) begin
                check("t6_data", got_d[idx], dat16[k % KPW_N_ELEM]);
                check("t6_last", got_l[idx], (k % KPW_N_ELEM == KPW_N_ELEM - 1) ? 32'h1 : 32'h0);
            end
        end
`ifdef KPW_PERF_CNT_EN
        check("t6_stall_cnt", stall_cnt, 32'd10);
`endif
        check("t6_end_busy", busy, 32'h0);
        check("t6_end_tile", tile_ready, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
